// File: rtl/lite16_mem_pkg.sv
// Shared constants, arbitration select type and counter helper for the lite16 program-ROM arbiter.
package lite16_mem_pkg;

    localparam int ROM_ADDR_W       = 16;
    localparam int ROM_DATA_W       = 16;
    localparam int PORT_F           = 0;
    localparam int PORT_D           = 1;
    localparam int NUM_PORTS        = 2;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_F    = 2'd1,
        ARB_D    = 2'd2
    } arb_sel_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry valid/ready response holder; a load in the same cycle as a consume keeps the slot full.
module rom_rsp_slot
    import lite16_mem_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // Slot occupancy and payload; payload only changes on load so it is stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (fetch/data) arbiter in front of the combinational program ROM.
// Optional performance counters are enabled with the ROM_ARBITER_PERF_EN macro.
module rom_arbiter
    import lite16_mem_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              f_rsp_ready,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    input  logic              d_rsp_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARBITER_PERF_EN
    ,
    output logic [15:0]       f_grant_cnt,
    output logic [15:0]       d_grant_cnt,
    output logic [15:0]       f_stall_cnt
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                  f_elig_s;
    logic                  d_elig_s;
    logic                  starve_hit_s;
    arb_sel_e              arb_sel_s;
    logic [NUM_PORTS-1:0]  gnt_s;
    logic [ADDR_W-1:0]     rom_addr_s;
    logic [ADDR_W-1:0]     last_addr_r;
    logic [STARVE_W-1:0]   starve_cnt_r;
    logic [STARVE_W-1:0]   starve_cnt_s;

    // A port may be served when its slot is empty or being drained this cycle.
    assign f_elig_s     = f_req && (!f_rsp_valid || f_rsp_ready);
    assign d_elig_s     = d_req && (!d_rsp_valid || d_rsp_ready);
    assign starve_hit_s = (starve_cnt_r == STARVE_MAX);

    // Priority select: D normally wins, F wins once it has waited STARVE_LIMIT cycles.
    always_comb begin
        arb_sel_s = ARB_NONE;
        if (!rst_n) begin
            arb_sel_s = ARB_NONE;
        end else if (f_elig_s && (starve_hit_s || !d_elig_s)) begin
            arb_sel_s = ARB_F;
        end else if (d_elig_s) begin
            arb_sel_s = ARB_D;
        end else begin
            arb_sel_s = ARB_NONE;
        end
    end

    // Decode the selection into per-port grants and the ROM address mux.
    always_comb begin
        gnt_s      = {NUM_PORTS{1'b0}};
        rom_addr_s = last_addr_r;
        case (arb_sel_s)
            ARB_F: begin
                gnt_s[PORT_F] = 1'b1;
                rom_addr_s    = f_addr;
            end
            ARB_D: begin
                gnt_s[PORT_D] = 1'b1;
                rom_addr_s    = d_addr;
            end
            default: begin
                gnt_s      = {NUM_PORTS{1'b0}};
                rom_addr_s = last_addr_r;
            end
        endcase
    end

    assign f_gnt    = gnt_s[PORT_F];
    assign d_gnt    = gnt_s[PORT_D];
    assign rom_addr = rom_addr_s;

    // Starvation counter: only waiting-while-eligible counts; an ineligible F holds its count.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (gnt_s[PORT_F] || !f_req) begin
            starve_cnt_s = {STARVE_W{1'b0}};
        end else if (f_elig_s && !starve_hit_s) begin
            starve_cnt_s = starve_cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Remember the last granted address so the ROM input is quiet on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr_r <= {ADDR_W{1'b0}};
        end else if (gnt_s != {NUM_PORTS{1'b0}}) begin
            last_addr_r <= rom_addr_s;
        end else begin
            last_addr_r <= last_addr_r;
        end
    end

    rom_rsp_slot #(.DATA_W(DATA_W)) u_f_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (gnt_s[PORT_F]),
        .load_data (rom_data),
        .ready     (f_rsp_ready),
        .valid     (f_rsp_valid),
        .data      (f_rsp_data)
    );

    rom_rsp_slot #(.DATA_W(DATA_W)) u_d_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (gnt_s[PORT_D]),
        .load_data (rom_data),
        .ready     (d_rsp_ready),
        .valid     (d_rsp_valid),
        .data      (d_rsp_data)
    );

`ifdef ROM_ARBITER_PERF_EN
    // Saturating grant and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_grant_cnt <= 16'h0000;
            d_grant_cnt <= 16'h0000;
            f_stall_cnt <= 16'h0000;
        end else begin
            f_grant_cnt <= gnt_s[PORT_F] ? sat_inc16(f_grant_cnt) : f_grant_cnt;
            d_grant_cnt <= gnt_s[PORT_D] ? sat_inc16(d_grant_cnt) : d_grant_cnt;
            f_stall_cnt <= (f_req && !gnt_s[PORT_F]) ? sat_inc16(f_stall_cnt) : f_stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: rule-level reference model checked every falling edge plus directed literal checks.
module tb_rom_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rsp_valid;
    logic [15:0] f_rsp_data;
    logic        f_rsp_ready;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [15:0] d_rsp_data;
    logic        d_rsp_ready;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
`ifdef ROM_ARBITER_PERF_EN
    logic [15:0] f_grant_cnt;
    logic [15:0] d_grant_cnt;
    logic [15:0] f_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rom_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_ready (f_rsp_ready),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_gnt       (d_gnt),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_ready (d_rsp_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data)
`ifdef ROM_ARBITER_PERF_EN
        ,
        .f_grant_cnt (f_grant_cnt),
        .d_grant_cnt (d_grant_cnt),
        .f_stall_cnt (f_stall_cnt)
`endif
    );

    // ROM contents: ROM[a] = a ^ C3C3
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: slot contents, starvation count and last address, advanced once per cycle.
    initial begin
        logic        m_fv, m_dv;
        logic [15:0] m_fd, m_dd, m_last, e_addr;
        int          m_starve;
        logic        f_el, d_el, f_win, d_win;
        m_fv = 1'b0; m_dv = 1'b0; m_fd = 16'h0000; m_dd = 16'h0000;
        m_last = 16'h0000; m_starve = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_fv = 1'b0; m_dv = 1'b0; m_fd = 16'h0000; m_dd = 16'h0000;
                m_last = 16'h0000; m_starve = 0;
                chk("m_rst_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
                chk("m_rst_valid", {30'd0, f_rsp_valid, d_rsp_valid}, 32'd0);
                chk("m_rst_data", {f_rsp_data, d_rsp_data}, 32'd0);
                chk("m_rst_addr", {16'd0, rom_addr}, 32'd0);
            end else begin
                f_el  = f_req && (!m_fv || f_rsp_ready);
                d_el  = d_req && (!m_dv || d_rsp_ready);
                f_win = f_el && (!d_el || (m_starve == LIMIT));
                d_win = d_el && !f_win;
                e_addr = f_win ? f_addr : (d_win ? d_addr : m_last);
                chk("m_f_gnt", {31'd0, f_gnt}, {31'd0, f_win});
                chk("m_d_gnt", {31'd0, d_gnt}, {31'd0, d_win});
                chk("m_rom_addr", {16'd0, rom_addr}, {16'd0, e_addr});
                chk("m_f_valid", {31'd0, f_rsp_valid}, {31'd0, m_fv});
                chk("m_d_valid", {31'd0, d_rsp_valid}, {31'd0, m_dv});
                chk("m_f_data", {16'd0, f_rsp_data}, {16'd0, m_fd});
                chk("m_d_data", {16'd0, d_rsp_data}, {16'd0, m_dd});
                if (f_win) begin
                    m_fv = 1'b1; m_fd = rom_fn(e_addr);
                end else if (m_fv && f_rsp_ready) begin
                    m_fv = 1'b0;
                end
                if (d_win) begin
                    m_dv = 1'b1; m_dd = rom_fn(e_addr);
                end else if (m_dv && d_rsp_ready) begin
                    m_dv = 1'b0;
                end
                if (f_win || !f_req) m_starve = 0;
                else if (f_el && m_starve < LIMIT) m_starve = m_starve + 1;
                if (f_win || d_win) m_last = e_addr;
            end
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        logic [15:0] exp_f [8];
        logic [9:0]  f_pat;
        exp_f[0] = 16'hC3C3; exp_f[1] = 16'hC3C2; exp_f[2] = 16'hC3C1; exp_f[3] = 16'hC3C0;
        exp_f[4] = 16'hC3C7; exp_f[5] = 16'hC3C6; exp_f[6] = 16'hC3C5; exp_f[7] = 16'hC3C4;
        f_pat = 10'b10000_10000;

        rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1;
        f_addr = 16'h0011; d_addr = 16'h0022; f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        #3;
        chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
        chk("rst_valid", {30'd0, f_rsp_valid, d_rsp_valid}, 32'd0);
        cyc(); cyc();
        f_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        cyc(); #2;
        chk("idle_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
        chk("idle_addr", {16'd0, rom_addr}, 32'd0);

        // Contention: D,D,D,D,F repeating
        cyc();
        f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0040; d_addr = 16'h0080;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) cyc();
            #2;
            chk("cont_f_gnt", {31'd0, f_gnt}, {31'd0, f_pat[k]});
            chk("cont_d_gnt", {31'd0, d_gnt}, {31'd0, !f_pat[k]});
        end
        cyc();
        f_req = 1'b0; d_req = 1'b0;
`ifdef ROM_ARBITER_PERF_EN
        #2;
        chk("perf_d_grant", {16'd0, d_grant_cnt}, 32'd8);
        chk("perf_f_grant", {16'd0, f_grant_cnt}, 32'd2);
        chk("perf_f_stall", {16'd0, f_stall_cnt}, 32'd8);
`endif

        // F only, addresses 0..7 back to back
        for (int i = 0; i < 8; i++) begin
            cyc();
            f_req = 1'b1; f_addr = 16'(i);
            #2;
            chk("fonly_gnt", {31'd0, f_gnt}, 32'd1);
            chk("fonly_addr", {16'd0, rom_addr}, i);
            if (i > 0) begin
                chk("fonly_data", {16'd0, f_rsp_data}, {16'd0, exp_f[i-1]});
                chk("fonly_valid", {31'd0, f_rsp_valid}, 32'd1);
            end
        end
        cyc();
        f_req = 1'b0;
        #2;
        chk("fonly_last", {16'd0, f_rsp_data}, {16'd0, exp_f[7]});

        // Backpressure on D while F keeps flowing
        cyc();
        d_req = 1'b1; d_addr = 16'h0003; d_rsp_ready = 1'b1;
        #2;
        chk("bp_d_first_gnt", {31'd0, d_gnt}, 32'd1);
        cyc();
        d_rsp_ready = 1'b0; d_addr = 16'h0009; f_req = 1'b1; f_addr = 16'h0010;
        for (int j = 0; j < 4; j++) begin
            if (j != 0) begin
                cyc();
                f_addr = 16'h0010 + 16'(j);
            end
            #2;
            chk("bp_d_data", {16'd0, d_rsp_data}, 32'h0000C3C0);
            chk("bp_d_valid", {31'd0, d_rsp_valid}, 32'd1);
            chk("bp_d_gnt", {31'd0, d_gnt}, 32'd0);
            chk("bp_f_gnt", {31'd0, f_gnt}, 32'd1);
        end
        cyc();
        d_rsp_ready = 1'b1;
        #2;
        chk("bp_release_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("bp_release_f_gnt", {31'd0, f_gnt}, 32'd0);

        // Same-cycle consume and reload at address 5
        cyc();
        f_req = 1'b0; d_addr = 16'h0005;
        #2;
        chk("rl_prev_data", {16'd0, d_rsp_data}, 32'h0000C3CA);
        chk("rl_gnt", {31'd0, d_gnt}, 32'd1);
        chk("rl_valid_now", {31'd0, d_rsp_valid}, 32'd1);
        cyc();
        d_req = 1'b0; d_rsp_ready = 1'b0;
        #2;
        chk("rl_valid_next", {31'd0, d_rsp_valid}, 32'd1);
        chk("rl_data_next", {16'd0, d_rsp_data}, 32'h0000C3C6);

        // Async reset mid-stream with both slots full
        cyc();
        d_req = 1'b1; d_addr = 16'h0002; f_req = 1'b1; f_addr = 16'h0004; f_rsp_ready = 1'b0;
        #2;
        chk("ar_f_gnt", {31'd0, f_gnt}, 32'd1);
        chk("ar_d_gnt", {31'd0, d_gnt}, 32'd0);
        cyc();
        #2;
        chk("ar_f_full", {15'd0, f_rsp_valid, f_rsp_data}, 32'h0001C3C7);
        chk("ar_d_full", {31'd0, d_rsp_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid_clr", {30'd0, f_rsp_valid, d_rsp_valid}, 32'd0);
        chk("ar_gnt_clr", {30'd0, f_gnt, d_gnt}, 32'd0);
        chk("ar_addr_clr", {16'd0, rom_addr}, 32'd0);
        cyc();
        f_req = 1'b0; d_req = 1'b0; f_rsp_ready = 1'b1; d_rsp_ready = 1'b1; rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            #2;
            chk("post_rst_idle", {29'd0, f_gnt, d_gnt, f_rsp_valid | d_rsp_valid}, 32'd0);
            chk("post_rst_addr", {16'd0, rom_addr}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
Shares the single combinational program ROM (16-bit address in, 16-bit word out) between two requesters: the instruction fetch port (F) and the data-load port (D), which reads constants and tables from program memory. Each cycle the block grants at most one request, drives the ROM address and captures the word into a per-port response slot. Slots use a valid/ready handshake. The block sits between the fetch/load units and the rom instance.

Parameters:
ADDR_W, 16, ROM address width
DATA_W, 16, ROM word width
STARVE_LIMIT, 4, consecutive denied cycles of F before F is forced to win (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request valid
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rsp_valid  out  1  fetch response slot holds data
f_rsp_data  out  DATA_W  fetch response word
f_rsp_ready  in  1  fetch consumer accepts response
d_req  in  1  data request valid
d_addr  in  ADDR_W  data address
d_gnt  out  1  data request accepted this cycle (combinational)
d_rsp_valid  out  1  data response slot holds data
d_rsp_data  out  DATA_W  data response word
d_rsp_ready  in  1  data consumer accepts response
rom_addr  out  ADDR_W  address to ROM
rom_data  in  DATA_W  ROM output word (combinational from rom_addr)

Behaviour:
- Reset (async, rst_n=0): f_rsp_valid=0, d_rsp_valid=0, rsp_data=0, starve counter=0. f_gnt=d_gnt=0 while in reset. rom_addr=0.
- Eligibility: a port is eligible when req=1 and (rsp_valid=0 or rsp_ready=1 in the same cycle). Free-on-consume gives full throughput.
- Arbitration: D has priority over F. Exception: if starve_cnt==STARVE_LIMIT and F is eligible, F wins. At most one gnt per cycle.
- starve_cnt: increments (saturating at STARVE_LIMIT) when F is eligible but not granted. Clears to 0 when F is granted or F is not requesting.
- rom_addr = granted port's address. With no grant, rom_addr holds its last value.
- Grant cycle N: rom_data is sampled at the end of cycle N into that port's slot. rsp_valid=1 from cycle N+1, so latency is 1 cycle.
- Slot: rsp_valid clears on valid&&ready unless the same port is granted that cycle, in which case it reloads and stays 1. Data is stable while valid&&!ready.
- Slots are independent. Backpressure on one port never blocks the other.
- Address wrap: none. The full ADDR_W space is forwarded unmodified.
- Reset mid-operation: pending responses are discarded and no grant is issued during reset. The first cycle after release behaves as idle.

Optional Feature:
- Macro: ROM_ARBITER_PERF_EN.
- Defined: adds output ports f_grant_cnt[15:0], d_grant_cnt[15:0] and f_stall_cnt[15:0].
  - Grant counters increment on each gnt.
  - f_stall_cnt increments each cycle F is requesting but not granted.
  - All three are saturating at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package lite16_mem_pkg:
  - ROM_ADDR_W=16, ROM_DATA_W=16.
  - Port index constants PORT_F=0, PORT_D=1.
  - Default STARVE_LIMIT.
- Sub-module rom_rsp_slot: one-entry valid/ready holding register with load/consume. Instantiated once per port.

Test Plan:
- F only: f_req=1, f_addr=0..7 back-to-back, f_rsp_ready=1.
  - Expect f_gnt every cycle.
  - Expect f_rsp_data = ROM[i] one cycle after address i.
  - Expect f_rsp_valid continuously high.
- Contention: f_req=d_req=1 continuously, STARVE_LIMIT=4, both ready.
  - Expect the grant pattern D,D,D,D,F repeating.
  - Expect starve_cnt to return to 0 after each F grant.
- Backpressure: d_rsp_ready=0 after the first D response at d_addr=3.
  - Expect d_rsp_data to stay at ROM[3] and d_gnt=0.
  - Meanwhile F is granted every cycle.
  - Raising d_rsp_ready gives a D grant the same cycle.
- Same-cycle consume+reload: D slot valid, d_rsp_ready=1, d_req=1 at address 5.
  - Expect d_gnt=1 and d_rsp_valid to stay 1.
  - Expect data to become ROM[5] next cycle.
- Async reset mid-stream: assert rst_n=0 between clock edges while both slots are valid.
  - Expect rsp_valid=0 and gnts=0 immediately.
  - After release with no requests, expect outputs to stay idle.
- With ROM_ARBITER_PERF_EN:
  - Run the contention scenario for 10 cycles; expect d_grant_cnt=8, f_grant_cnt=2 and f_stall_cnt=8.
  - Check saturation by forcing the counters near 16'hFFFF.
